// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start/done handshake and operand/result bundle for serial_subtractor.
//   start       : request, accepted when the subtractor is idle or done
//   In1, In2    : minuend / subtrahend, WIDTH bits
//   Bin         : borrow-in
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   Diff        : (In1 - In2 - Bin) mod 2^WIDTH
//   Bout        : unsigned borrow out of the MSB
//   Ovf         : signed two's-complement overflow
//   Zero        : Diff == 0
// master = requester side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] In1;
   logic [WIDTH-1:0] In2;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
   logic             Ovf;
   logic             Zero;

   modport master (
      output start, In1, In2, Bin,
      input  busy, done, Diff, Bout, Ovf, Zero
   );

   modport slave (
      input  start, In1, In2, Bin,
      output busy, done, Diff, Bout, Ovf, Zero
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Digit-serial WIDTH-bit subtractor: Diff = In1 - In2 - Bin, processed least
// significant digit first, DIGIT bits per clock (S = WIDTH/DIGIT steps).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_subtractor_if slave (start/In1/In2/Bin in,
//         busy/done/Diff/Bout/Ovf/Zero out)
// Results are updated only on the completing edge and held until the next
// completion or reset.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int S  = WIDTH / DIGIT;
   localparam int CW = (S > 1) ? $clog2(S) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ripple-borrow subtract of one digit.
   // Returns {borrow into digit MSB, borrow out, difference digit}; the
   // borrow into the MSB is what the overflow flag needs on the last digit.
   function automatic logic [DIGIT+1:0] sub_digit(
      input logic [DIGIT-1:0] a,
      input logic [DIGIT-1:0] b,
      input logic             bin
   );
      logic             br;
      logic             msb_bin;
      logic [DIGIT-1:0] d;
      br      = bin;
      msb_bin = bin;
      d       = {DIGIT{1'b0}};
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) begin
            msb_bin = br;
         end else begin
            msb_bin = msb_bin;
         end
         d[i] = a[i] ^ b[i] ^ br;
         br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
      end
      return {msb_bin, br, d};
   endfunction

   state_t                 state_q,  state_d;
   logic [WIDTH-1:0]       a_q,      a_d;
   logic [WIDTH-1:0]       b_q,      b_d;
   // Holds the S-1 digits already produced; the final digit joins on completion.
   logic [WIDTH-DIGIT-1:0] res_q,    res_d;
   logic                   borrow_q, borrow_d;
   logic [CW-1:0]          cnt_q,    cnt_d;
   logic [WIDTH-1:0]       diff_q,   diff_d;
   logic                   bout_q,   bout_d;
   logic                   ovf_q,    ovf_d;
   logic                   zero_q,   zero_d;

   logic [DIGIT+1:0]       digit_s;
   logic [WIDTH-1:0]       res_shift_s;
   logic                   last_s;

   // Digit datapath: current digit result and the result register shifted in from the MSB side.
   always_comb begin
      digit_s     = sub_digit(a_q[DIGIT-1:0], b_q[DIGIT-1:0], borrow_q);
      res_shift_s = {digit_s[DIGIT-1:0], res_q};
      last_s      = (cnt_q == CW'(S - 1));
   end

   // Next-state and next-register logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               a_d      = bus.In1;
               b_d      = bus.In2;
               res_d    = {(WIDTH-DIGIT){1'b0}};
               borrow_d = bus.Bin;
               cnt_d    = {CW{1'b0}};
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            // start is deliberately not looked at here: no queuing while running.
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            res_d    = res_shift_s[WIDTH-1:DIGIT];
            borrow_d = digit_s[DIGIT];
            if (last_s) begin
               cnt_d   = {CW{1'b0}};
               diff_d  = res_shift_s;
               bout_d  = digit_s[DIGIT];
               ovf_d   = digit_s[DIGIT+1] ^ digit_s[DIGIT];
               zero_d  = (res_shift_s == {WIDTH{1'b0}});
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         res_q    <= {(WIDTH-DIGIT){1'b0}};
         borrow_q <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         diff_q   <= {WIDTH{1'b0}};
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);
   assign bus.Diff = diff_q;
   assign bus.Bout = bout_q;
   assign bus.Ovf  = ovf_q;
   assign bus.Zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboarded bench for serial_subtractor with a DIGIT=1 and a DIGIT=4
// instance. Drivers push hand-computed expectations (including the cycle in
// which done must appear); monitors pop and compare on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q1[$];
   exp_t q4[$];
   logic prev1, prev4;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor_if #(.WIDTH(32)) if1 ();
   serial_subtractor_if #(.WIDTH(32)) if4 ();

   serial_subtractor #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic cmp_result(input string tag, input exp_t e, input logic [31:0] diff,
                             input logic bout, input logic ovf, input logic zero);
      chk({tag, "_diff"}, diff, e.diff);
      chk({tag, "_bout"}, {31'b0, bout}, {31'b0, e.bout});
      chk({tag, "_ovf"},  {31'b0, ovf},  {31'b0, e.ovf});
      chk({tag, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
      chk({tag, "_cycle"}, cyc, e.cyc);
   endtask

   // Monitor for the DIGIT=1 instance
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev1 <= 1'b0;
      end else begin
         if (if1.done) begin
            chk("d1_done_twice", {31'b0, prev1}, 32'd0);
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d1_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               e = q1.pop_front();
               cmp_result("d1", e, if1.Diff, if1.Bout, if1.Ovf, if1.Zero);
            end
         end
         prev1 <= if1.done;
      end
   end

   // Monitor for the DIGIT=4 instance
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev4 <= 1'b0;
      end else begin
         if (if4.done) begin
            chk("d4_done_twice", {31'b0, prev4}, 32'd0);
            if (q4.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d4_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               e = q4.pop_front();
               cmp_result("d4", e, if4.Diff, if4.Bout, if4.Ovf, if4.Zero);
            end
         end
         prev4 <= if4.done;
      end
   end

   // Issue one DIGIT=1 operation (called on a negedge, returns on the negedge after acceptance)
   task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input logic push, input logic [31:0] ed, input logic eb,
                         input logic eo, input logic ez);
      exp_t e;
      if1.In1   = a;
      if1.In2   = b;
      if1.Bin   = bin;
      if1.start = 1'b1;
      e.diff = ed; e.bout = eb; e.ovf = eo; e.zero = ez;
      e.cyc  = cyc + 1 + 32;
      if (push) q1.push_back(e);
      @(negedge clk);
      if1.start = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      for (k = 0; k < 120; k++) begin
         if (q1.size() == 0 && q4.size() == 0) break;
         @(negedge clk);
      end
      chk(name, q1.size() + q4.size(), 32'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy1"}, {31'b0, if1.busy}, 32'd0);
      chk({tag, "_done1"}, {31'b0, if1.done}, 32'd0);
      chk({tag, "_diff1"}, if1.Diff, 32'd0);
      chk({tag, "_flags1"}, {29'b0, if1.Bout, if1.Ovf, if1.Zero}, 32'd0);
      chk({tag, "_busy4"}, {31'b0, if4.busy}, 32'd0);
      chk({tag, "_diff4"}, if4.Diff, 32'd0);
      chk({tag, "_flags4"}, {29'b0, if4.Bout, if4.Ovf, if4.Zero}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      int   c;
      exp_t e;
      rst = 1'b1;
      if1.start = 1'b0; if1.In1 = 32'd0; if1.In2 = 32'd0; if1.Bin = 1'b0;
      if4.start = 1'b0; if4.In1 = 32'd0; if4.In2 = 32'd0; if4.Bin = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Equal operands: zero result, busy for exactly 32 cycles
      issue1(32'h80000001, 32'h80000001, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
      n = 0;
      for (int k = 0; k < 60; k++) begin
         if (if1.done) break;
         if (if1.busy) n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 32'd32);
      drain("t1_drain");

      issue1(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
      drain("t2_drain");
      issue1(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      drain("t3a_drain");
      issue1(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
      drain("t3b_drain");

      // Reset 10 cycles into RUN: outputs cleared, aborted op never completes
      issue1(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("midrun_reset");
      rst = 1'b0;
      repeat (40) @(negedge clk);

      issue1(32'd10, 32'd20, 1'b0, 1'b1, 32'hFFFFFFF6, 1'b1, 1'b0, 1'b0);
      drain("t6_drain");

      // start re-pulsed mid-RUN with new operands must be ignored
      issue1(32'd5, 32'd3, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      if1.In1 = 32'hFFFFFFFF; if1.In2 = 32'hFFFFFFFF; if1.Bin = 1'b0;
      if1.start = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      drain("t5_drain");
      repeat (40) @(negedge clk);

      // Borrow-in alone causes signed overflow
      issue1(32'h80000000, 32'h00000000, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      drain("t7_drain");

      // DIGIT=4: start held through DONE, second op accepted back-to-back
      c = cyc;
      if4.In1 = 32'h12345678; if4.In2 = 32'h01234567; if4.Bin = 1'b0;
      if4.start = 1'b1;
      e.diff = 32'h11111111; e.bout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.cyc = c + 9;
      q4.push_back(e);
      @(negedge clk);
      if4.In1 = 32'h00000000; if4.In2 = 32'h00000000; if4.Bin = 1'b1;
      e.diff = 32'hFFFFFFFF; e.bout = 1'b1; e.ovf = 1'b0; e.zero = 1'b0; e.cyc = c + 18;
      q4.push_back(e);
      for (int k = 0; k < 20; k++) begin
         if (cyc >= c + 10) break;
         @(negedge clk);
      end
      chk("d4_b2b_busy", {31'b0, if4.busy}, 32'd1);
      chk("d4_b2b_done", {31'b0, if4.done}, 32'd0);
      if4.start = 1'b0;
      drain("d4_drain");
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Multi-cycle, digit-serial WIDTH-bit subtractor with borrow-in and borrow-out. Computes Diff = In1 − In2 − Bin least-significant digit first, DIGIT bits per clock.
- It is the subtract counterpart of the team's combinational 32-bit adder and sits in the same datapath wherever a small-area, start/done-handshaked difference is acceptable.
- Also reports unsigned borrow, signed overflow and zero flags.

## Interface
- WIDTH, 32, operand/result width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH must be an integer multiple of DIGIT. S = WIDTH/DIGIT digit steps.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  request; sampled on clk edge, accepted only in IDLE or DONE.
- In1  input  WIDTH  minuend; captured on the accepting edge.
- In2  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, results valid.
- Diff  output  WIDTH  result (In1 − In2 − Bin) mod 2^WIDTH.
- Bout  output  1  borrow out of the MSB: 1 iff unsigned In1 < In2 + Bin.
- Ovf  output  1  signed (two's-complement) overflow of the subtraction.
- Zero  output  1  Diff == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Latch In1, In2 into working shift registers.
  - Load borrow flop with Bin and digit counter with 0.
  - Go to RUN.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- RUN, each edge, for the current low DIGIT bits:
  - Compute {b, d} = a_dig − b_dig − borrow.
  - Shift d into the result register from the MSB side.
  - Shift both operand registers right by DIGIT.
  - Set borrow to b and increment the counter.
- RUN, on the edge processing digit S−1 (the last digit):
  - Copy the completed result into Diff and the final borrow into Bout.
  - Update Ovf and Zero.
  - Go to DONE with done=1.
- Ovf = borrow into MSB XOR borrow out of MSB. Equivalent: true signed value of In1 − In2 − Bin lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. For DIGIT>1, track the borrow into the MSB inside the last digit.
- Diff, Bout, Ovf, Zero change only on the completing edge and hold until the next completion or reset. Partial results are never visible.
- start while in RUN is ignored: no queuing, operands unchanged.
- Input changes after the accepting edge have no effect on the running operation.

## Timing
- Reset (rst=1 on an edge):
  - State goes to IDLE.
  - busy=0, done=0, Diff=0, Bout=0, Ovf=0, Zero=0.
  - Working registers and counter cleared.
  - rst has priority over start.
- Reset mid-RUN aborts the operation: no done pulse, outputs reset to 0.
- Latency: start accepted on edge E0. busy=1 from E0 through E(S−1), then 0 from ES. done=1 for the one cycle between ES and E(S+1).
  - DIGIT=1: done rises 32 edges after acceptance.
  - DIGIT=4: done rises 8 edges after acceptance.
- Back-to-back: start=1 during the DONE cycle is accepted on E(S+1). busy then rises and done falls on that same edge. Throughput is one operation per S+1 cycles.
- done is never asserted for two consecutive cycles.

## Test plan
- WIDTH=32, DIGIT=1, In1=In2=0x80000001, Bin=0, start pulse → done 32 edges after acceptance with Diff=0x00000000, Bout=0, Ovf=0, Zero=1; busy high for exactly 32 cycles.
- In1=0x00000000, In2=0x00000001, Bin=0 → Diff=0xFFFFFFFF, Bout=1, Ovf=0, Zero=0.
- In1=0x80000000, In2=0x00000001, Bin=0 → Diff=0x7FFFFFFF, Bout=0, Ovf=1. Then In1=0x7FFFFFFF, In2=0xFFFFFFFF → Diff=0x80000000, Bout=1, Ovf=1.
- In1=5, In2=3, Bin=1, with start re-pulsed and In1/In2 changed to 0xFFFFFFFF mid-RUN → Diff=0x00000001, Bout=0, Zero=0; second start ignored, exactly one done.
- rst=1 at 10 cycles into RUN → all outputs 0 on the next edge and no done pulse. A subsequent start with In1=10, In2=20 → Diff=0xFFFFFFF6, Bout=1.
- DIGIT=4 instance: In1=0x12345678, In2=0x01234567, then start held high through the DONE cycle → first done 8 edges after acceptance with Diff=0x11111111, Bout=0. The second operation is accepted in the DONE cycle and its done arrives 9 edges after the first.
